// File: rtl/regfile_op_sequencer.sv
// Command-driven master for an 8x8 register file: reads operands, executes one
// ALU/move op, writes the result back and returns it on a response channel.
module regfile_op_sequencer #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [DW-1:0] cmd_imm,
  output logic [AW-1:0] rf_raddr1,
  output logic [AW-1:0] rf_raddr2,
  input  logic [DW-1:0] rf_rdata1,
  input  logic [DW-1:0] rf_rdata2,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_carry,
  output logic          rsp_zero
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDI = 3'd5;
  localparam logic [2:0] OP_MOV = 3'd6;
  localparam logic [2:0] OP_RD  = 3'd7;

  logic [2:0]    state, state_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [DW-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [DW-1:0] res_q, res_d;
  logic          carry_q, carry_d;

  logic          cmd_ready_d, rf_we_d, rsp_valid_d, rsp_carry_d, rsp_zero_d;
  logic [AW-1:0] rf_raddr1_d, rf_raddr2_d, rf_waddr_d;
  logic [DW-1:0] rf_wdata_d, rsp_data_d;

  logic [DW:0]   sum;
  logic [DW-1:0] alu_res;
  logic          alu_carry;

  // Datapath: result and carry/borrow from the latched operands
  assign sum = {1'b0, opa_q} + {1'b0, opb_q};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin alu_res = sum[DW-1:0]; alu_carry = sum[DW]; end
      OP_SUB: begin alu_res = opa_q - opb_q; alu_carry = (opa_q < opb_q); end
      OP_AND: alu_res = opa_q & opb_q;
      OP_OR:  alu_res = opa_q | opb_q;
      OP_XOR: alu_res = opa_q ^ opb_q;
      OP_LDI: alu_res = imm_q;
      OP_MOV: alu_res = opa_q;
      OP_RD:  alu_res = opa_q;
      default: alu_res = '0;
    endcase
  end

  // Next-state and next-output logic; every output is registered
  always_comb begin
    state_d     = state;
    op_d        = op_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res_d       = res_q;
    carry_d     = carry_q;
    cmd_ready_d = cmd_ready;
    rf_raddr1_d = rf_raddr1;
    rf_raddr2_d = rf_raddr2;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr;
    rf_wdata_d  = rf_wdata;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_carry_d = rsp_carry;
    rsp_zero_d  = rsp_zero;
    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d        = cmd_op;
          rd_d        = cmd_rd;
          imm_d       = cmd_imm;
          rf_raddr1_d = cmd_rs1;
          rf_raddr2_d = cmd_rs2;
          cmd_ready_d = 1'b0;
          state_d     = S_READ;
        end
      end
      S_READ: begin
        opa_d   = rf_rdata1;
        opb_d   = rf_rdata2;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_res;
        carry_d = alu_carry;
        if (op_q == OP_RD) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = alu_res;
          rsp_carry_d = alu_carry;
          rsp_zero_d  = (alu_res == '0);
          state_d     = S_RESP;
        end else begin
          rf_we_d    = 1'b1;
          rf_waddr_d = rd_q;
          rf_wdata_d = alu_res;
          state_d    = S_WB;
        end
      end
      S_WB: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = res_q;
        rsp_carry_d = carry_q;
        rsp_zero_d  = (res_q == '0);
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers; cmd_ready resets high since reset lands in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      cmd_ready <= 1'b1;
      rf_raddr1 <= '0;
      rf_raddr2 <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
    end else begin
      state     <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      cmd_ready <= cmd_ready_d;
      rf_raddr1 <= rf_raddr1_d;
      rf_raddr2 <= rf_raddr2_d;
      rf_we     <= rf_we_d;
      rf_waddr  <= rf_waddr_d;
      rf_wdata  <= rf_wdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_carry <= rsp_carry_d;
      rsp_zero  <= rsp_zero_d;
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer: a register file environment, an
// op-level reference model, and a per-cycle compare process.
module tb_regfile_op_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [DW-1:0] cmd_imm;
  logic [AW-1:0] rf_raddr1, rf_raddr2, rf_waddr;
  logic [DW-1:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic          rf_we;
  logic          rsp_valid, rsp_ready, rsp_carry, rsp_zero;
  logic [DW-1:0] rsp_data;

  regfile_op_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;

  // Register file the DUT drives: combinational read, clocked write
  logic [DW-1:0] rf_mem [8];
  logic          mem_init;
  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= 8'(i * 37 + 11);
    end else if (rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end

  logic [DW-1:0] mdl [8];
  int            checks = 0;
  int            errors = 0;
  int            we_cnt;
  logic          busy, started;
  logic [DW-1:0] exp_data, exp_wdata;
  logic          exp_carry, exp_zero;
  logic [AW-1:0] exp_waddr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference semantics of one command: result, carry/borrow, writes-back flag
  function automatic void ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] imm, output logic [7:0] r, output logic c,
                                 output logic wr);
    int unsigned s;
    c  = 1'b0;
    wr = 1'b1;
    r  = 8'h00;
    case (op)
      3'd0: begin s = 32'(a) + 32'(b); r = 8'(s % 256); c = (s > 255); end
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = imm;
      3'd6: r = a;
      default: begin r = a; wr = 1'b0; end
    endcase
  endfunction

  // Every cycle: handshake readiness, response payload and write traffic
  always @(negedge clk) begin
    if (!rst && started) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(!busy));
      if (rsp_valid) begin
        chk("rsp_data", 32'(rsp_data), 32'(exp_data));
        chk("rsp_carry", 32'(rsp_carry), 32'(exp_carry));
        chk("rsp_zero", 32'(rsp_zero), 32'(exp_zero));
      end
      if (rf_we) begin
        we_cnt++;
        chk("rf_waddr", 32'(rf_waddr), 32'(exp_waddr));
        chk("rf_wdata", 32'(rf_wdata), 32'(exp_wdata));
      end
      if (!busy) begin
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_rf_we", 32'(rf_we), 32'd0);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    busy = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic scramble_cmd();
    cmd_op  = 3'($urandom);
    cmd_rd  = 3'($urandom);
    cmd_rs1 = 3'($urandom);
    cmd_rs2 = 3'($urandom);
    cmd_imm = 8'($urandom);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [7:0] imm, input int hold,
                         input bit junk, output logic [7:0] got_d, output logic got_c,
                         output logic got_z, output int got_we);
    logic [7:0] r;
    logic c, wr;
    int lat;
    @(negedge clk);
    ref_op(op, mdl[rs1], mdl[rs2], imm, r, c, wr);
    exp_data = r; exp_carry = c; exp_zero = (r == 8'h00);
    exp_waddr = rd; exp_wdata = r;
    we_cnt = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    @(posedge clk);
    busy = 1'b1;
    @(negedge clk);
    if (junk) scramble_cmd(); else cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 16) begin
      @(negedge clk);
      lat++;
      if (junk) scramble_cmd();
    end
    chk("latency", 32'(lat), wr ? 32'd4 : 32'd3);
    got_d = rsp_data; got_c = rsp_carry; got_z = rsp_zero; got_we = we_cnt;
    if (!rsp_valid) begin
      do_reset();
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (junk) scramble_cmd();
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    busy = 1'b0;
    if (wr) mdl[rd] = r;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    chk("we_pulses", 32'(we_cnt), wr ? 32'd1 : 32'd0);
    got_we = we_cnt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] d, r;
    logic c, z, wr;
    int we, n;
    rst = 1'b1; mem_init = 1'b1; busy = 1'b0; started = 1'b0;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
    we_cnt = 0; exp_data = '0; exp_wdata = '0; exp_carry = 1'b0; exp_zero = 1'b0; exp_waddr = '0;
    for (int i = 0; i < 8; i++) mdl[i] = 8'(i * 37 + 11);
    #2;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    repeat (2) @(negedge clk);
    mem_init = 1'b0; rst = 1'b0; started = 1'b1;

    // LDI then RD of the same register
    run_cmd(3'd5, 3'd3, 3'd0, 3'd0, 8'h5A, 0, 1'b0, d, c, z, we);
    chk("ldi_data", 32'(d), 32'h5A);
    chk("ldi_we", 32'(we), 32'd1);
    run_cmd(3'd7, 3'd0, 3'd3, 3'd0, 8'h00, 0, 1'b0, d, c, z, we);
    chk("rd_data", 32'(d), 32'h5A);
    chk("rd_zero", 32'(z), 32'd0);
    chk("rd_we", 32'(we), 32'd0);

    // ADD with carry out, then rd == rs1 == rs2
    run_cmd(3'd5, 3'd1, 3'd0, 3'd0, 8'hF0, 0, 1'b0, d, c, z, we);
    run_cmd(3'd5, 3'd2, 3'd0, 3'd0, 8'h20, 0, 1'b0, d, c, z, we);
    run_cmd(3'd0, 3'd4, 3'd1, 3'd2, 8'h00, 0, 1'b0, d, c, z, we);
    chk("add_data", 32'(d), 32'h10);
    chk("add_carry", 32'(c), 32'd1);
    run_cmd(3'd0, 3'd1, 3'd1, 3'd1, 8'h00, 0, 1'b0, d, c, z, we);
    chk("add_self_data", 32'(d), 32'hE0);
    chk("add_self_carry", 32'(c), 32'd1);
    run_cmd(3'd7, 3'd0, 3'd1, 3'd0, 8'h00, 0, 1'b0, d, c, z, we);
    chk("rd_r1", 32'(d), 32'hE0);

    // SUB with borrow, and SUB to zero
    run_cmd(3'd5, 3'd5, 3'd0, 3'd0, 8'h05, 0, 1'b0, d, c, z, we);
    run_cmd(3'd5, 3'd6, 3'd0, 3'd0, 8'h07, 0, 1'b0, d, c, z, we);
    run_cmd(3'd1, 3'd7, 3'd5, 3'd6, 8'h00, 0, 1'b0, d, c, z, we);
    chk("sub_data", 32'(d), 32'hFE);
    chk("sub_borrow", 32'(c), 32'd1);
    run_cmd(3'd1, 3'd0, 3'd5, 3'd5, 8'h00, 0, 1'b0, d, c, z, we);
    chk("sub0_data", 32'(d), 32'h00);
    chk("sub0_zero", 32'(z), 32'd1);
    chk("sub0_carry", 32'(c), 32'd0);

    // Backpressure with cmd_valid held during busy states
    run_cmd(3'd0, 3'd3, 3'd5, 3'd6, 8'h00, 5, 1'b1, d, c, z, we);
    chk("bp_data", 32'(d), 32'h0C);
    chk("bp_carry", 32'(c), 32'd0);

    // Reset during WB of ADD into r2 aborts the write and the response
    @(negedge clk);
    ref_op(3'd0, mdl[1], mdl[4], 8'h00, r, c, wr);
    exp_data = r; exp_carry = c; exp_zero = (r == 8'h00); exp_waddr = 3'd2; exp_wdata = r;
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_rd = 3'd2; cmd_rs1 = 3'd1; cmd_rs2 = 3'd4; cmd_imm = 8'h00;
    @(posedge clk);
    busy = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rf_we && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("wb_reached", 32'(rf_we), 32'd1);
    rst = 1'b1;
    busy = 1'b0;
    #1;
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("arst_rf_we", 32'(rf_we), 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_addrs", 32'({rf_raddr1, rf_raddr2, rf_waddr}), 32'd0);
    chk("arst_data", 32'({rf_wdata, rsp_data, rsp_carry, rsp_zero}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    run_cmd(3'd7, 3'd0, 3'd2, 3'd0, 8'h00, 0, 1'b0, d, c, z, we);
    chk("abort_no_write", 32'(d), 32'h20);
    run_cmd(3'd5, 3'd2, 3'd0, 3'd0, 8'h33, 1, 1'b0, d, c, z, we);
    run_cmd(3'd7, 3'd0, 3'd2, 3'd0, 8'h00, 0, 1'b0, d, c, z, we);
    chk("post_reset_ldi_rd", 32'(d), 32'h33);

    // Randomized commands against the model
    for (int k = 0; k < 60; k++) begin
      run_cmd(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom), d, c, z, we);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
Command-driven master for the 8x8 register file. It issues the file's read and write port traffic: it accepts one ALU/move command via valid/ready, reads the operands, computes the result, writes it back, and returns the result on a response valid/ready channel. It sits between a command source (test controller or simple decoder) and the register file. It is a multi-cycle, one-command-at-a-time FSM.

Parameters:
DW, 8, data width (matches register file word width)
AW, 3, register address width (2^AW registers)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  3  opcode (see Behaviour)
cmd_rd  input  AW  destination register
cmd_rs1  input  AW  source register 1
cmd_rs2  input  AW  source register 2
cmd_imm  input  DW  immediate for LDI
rf_raddr1  output  AW  register file read address 1
rf_raddr2  output  AW  register file read address 2
rf_rdata1  input  DW  register file read data 1 (combinational from file)
rf_rdata2  input  DW  register file read data 2
rf_we  output  1  register file write enable
rf_waddr  output  AW  register file write address
rf_wdata  output  DW  register file write data
rsp_valid  output  1  response present
rsp_ready  input  1  response consumer ready
rsp_data  output  DW  result value
rsp_carry  output  1  carry (ADD) / borrow (SUB), else 0
rsp_zero  output  1  1 when rsp_data == 0

Behaviour:
- Reset is asynchronous and active-high. Reset clears the state to IDLE and sets every output and internal register to 0, except cmd_ready, which is 1 once in IDLE. Reset mid-command aborts the command with no write and no response.
- Opcodes:
  - 000 ADD: rd = rs1 + rs2, carry = bit DW of the sum.
  - 001 SUB: rd = rs1 - rs2, carry = borrow (rs1 < rs2, unsigned).
  - 010 AND, 011 OR, 100 XOR: bitwise.
  - 101 LDI: rd = imm.
  - 110 MOV: rd = rs1.
  - 111 RD: no writeback; rsp_data = rs1.
- Results wrap modulo 2^DW. Carry is 0 for all ops except ADD and SUB.
- FSM states: IDLE, READ, EXEC, WB, RESP.
  - IDLE: cmd_ready = 1. On cmd_valid & cmd_ready, capture op/rd/rs1/rs2/imm, then go to READ.
  - READ: rf_raddr1/2 are driven from the captured rs1/rs2 (registered outputs, stable all command long). At the end of the cycle, latch rf_rdata1/2 into operand registers, then go to EXEC.
  - EXEC: compute result and carry into registers. Go to RESP if op = RD, else go to WB.
  - WB: rf_we = 1 for exactly this one cycle, with rf_waddr = rd and rf_wdata = result. Go to RESP.
  - RESP: rsp_valid = 1. rsp_data, rsp_carry and rsp_zero stay stable until rsp_ready is sampled high, then go to IDLE.
- cmd_ready is 0 in every state except IDLE. cmd_valid is ignored outside IDLE.
- rf_we is 0 outside WB.
- Latency from the accept edge to the first cycle with rsp_valid high:
  - 4 cycles for write ops.
  - 3 cycles for RD.
- Minimum command period: 5 cycles for write ops (4 for RD) with rsp_ready held high.
- Hazards: the write commits at the WB→RESP edge, before any later READ, so back-to-back dependent commands always see the updated value. No forwarding is needed.
- rd equal to rs1 or rs2 is legal: operands are latched before writeback.
- rsp_valid drops in the cycle after the handshake. cmd_ready rises in that same cycle.

Test Plan:
- Reset: assert rst mid-run → cmd_ready=1, rf_we=0, rsp_valid=0, all address/data outputs 0 immediately, without waiting for a clock.
- LDI rd=3, imm=0x5A, then RD rs1=3 → first rsp_data=0x5A with exactly one rf_we pulse (waddr=3, wdata=0x5A). Second rsp_data=0x5A, zero=0, and no rf_we pulse.
- ADD with r1=0xF0, r2=0x20, rd=4 → rsp_data=0x10, carry=1. ADD r1+r1 into rd=1 → 0xE0, carry=1, and a later RD of r1 returns 0xE0.
- SUB with r5=0x05, r6=0x07 → 0xFE, carry=1. SUB r5-r5 → 0x00, zero=1, carry=0.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid and rsp_data stay stable. cmd_valid pulsed during busy states is not accepted; cmd_ready stays 0 until the cycle after the rsp handshake.
- Reset during WB of ADD into r2 → no response appears, and after reset, LDI/RD checks show the register-file side received no write from the aborted command.
